prog_clock_divider: RTL and testbench

//   Multi-channel programmable clock-enable generator for the lab designs.

---
 rtl/prog_clkdiv_pkg.sv | 17 +
 rtl/clkdiv_channel.sv | 77 +++++++
 rtl/prog_clock_divider.sv | 70 +++++++
 tb/tb_prog_clock_divider.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clkdiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_clkdiv_pkg : shared defaults and divisor clamp               |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package prog_clkdiv_pkg;

    localparam int DEF_CNT_W = 26;
    localparam int DEF_DIV   = 25000000;

    // Divisors 0 and 1 both mean "tick every cycle".
    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'd2) ? 32'd1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clkdiv_channel : one programmable tick / slow_clk divider channel |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module clkdiv_channel
    import prog_clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             restart,
    output logic             tick,
    output logic             slow_clk
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic [CNT_W-1:0] shadow_nxt;
    logic [CNT_W-1:0] commit_div;

    // The active divisor only matters at the instant it is loaded into the
    // counter, so committing the shadow is the reload itself. A value written
    // in the same cycle as a commit is the one that gets used.
    always_comb begin
        shadow_nxt = load ? load_value : shadow_q;
        commit_div = CNT_W'(clamp_div(32'(shadow_nxt)));
        shadow_d   = shadow_nxt;
        count_d    = count_q;
        tick_d     = 1'b0;
        slow_d     = slow_q;
        if (restart) begin
            count_d = commit_div - CNT_ONE;
            slow_d  = 1'b0;
        end else if (!en) begin
            if (load) begin
                count_d = commit_div - CNT_ONE;
            end
        end else if (count_q == '0) begin
            tick_d  = 1'b1;
            slow_d  = ~slow_q;
            count_d = commit_div - CNT_ONE;
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= RST_DIV;
            count_q  <= RST_CNT;
            tick_q   <= 1'b0;
            slow_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            slow_q   <= slow_d;
        end
    end

    assign tick     = tick_q;
    assign slow_clk = slow_q;

endmodule
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_clock_divider : multi-channel programmable clock enables     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module prog_clock_divider
    import prog_clkdiv_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = DEF_CNT_W,
    parameter int  DEFAULT_DIV = DEF_DIV,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              div_load,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_value,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [31:0]       divided_clocks
);

    logic [31:0]       divided_clocks_q, divided_clocks_d;
    logic [NUM_CH-1:0] load_vec;

    always_comb begin
        divided_clocks_d = divided_clocks_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divided_clocks_q <= 32'd0;
        end else begin
            divided_clocks_q <= divided_clocks_d;
        end
    end

    assign divided_clocks = divided_clocks_q;

    // Codes at or above NUM_CH match no channel, so such loads vanish.
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_vec[i] = div_load && (div_sel == SEL_W'(i));
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            clkdiv_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clk        (clk),
                .reset_n    (reset_n),
                .en         (ch_en[g]),
                .load       (load_vec[g]),
                .load_value (div_value),
                .restart    (sync_restart),
                .tick       (tick[g]),
                .slow_clk   (slow_clk[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_prog_clock_divider : self-checking bench for prog_clock_divider|
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_prog_clock_divider;

    // Five channels leave div_sel codes 5..7 unused.
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 5;

    logic              clk;
    logic              reset_n;
    logic              div_load;
    logic [2:0]        div_sel;
    logic [CNT_W-1:0]  div_value;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] slow_clk;
    logic [31:0]       divided_clocks;

    prog_clock_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .div_load       (div_load),
        .div_sel        (div_sel),
        .div_value      (div_value),
        .ch_en          (ch_en),
        .sync_restart   (sync_restart),
        .tick           (tick),
        .slow_clk       (slow_clk),
        .divided_clocks (divided_clocks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cycles left until the next tick, plus the latest divisor.
    int                m_rem    [NUM_CH];
    int                m_shadow [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_slow;
    logic [31:0]       m_dc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_rem[c]    = DDIV;
            m_shadow[c] = DDIV;
        end
        m_tick = '0;
        m_slow = '0;
        m_dc   = 32'd0;
    endtask

    task automatic model_edge();
        m_dc = m_dc + 32'd1;
        for (int c = 0; c < NUM_CH; c++) begin
            bit hit;
            int eff;
            int period;
            hit    = div_load && (int'(div_sel) == c);
            eff    = hit ? int'(div_value) : m_shadow[c];
            period = (eff < 2) ? 1 : eff;
            m_shadow[c] = eff;
            if (sync_restart) begin
                m_rem[c]  = period;
                m_slow[c] = 1'b0;
                m_tick[c] = 1'b0;
            end else if (!ch_en[c]) begin
                m_tick[c] = 1'b0;
                if (hit) m_rem[c] = period;
            end else begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_slow[c] = ~m_slow[c];
                    m_rem[c]  = period;
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(tick), 32'(m_tick));
        check("slow_clk", 32'(slow_clk), 32'(m_slow));
        check("divided_clocks", divided_clocks, m_dc);
    endtask

    task automatic idle_inputs();
        div_load     = 1'b0;
        div_sel      = 3'd0;
        div_value    = '0;
        sync_restart = 1'b0;
    endtask

    typedef struct packed {
        logic       load;
        logic [2:0] sel;
        logic [7:0] val;
        logic [1:0] exp_tick;
        logic [1:0] exp_slow;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Edges 1..15 after reset release; ch1 gets divisor 3 while at count 2.
        tbl[0]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 3'd1, 8'd3, 2'b00, 2'b00};
        tbl[3]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 3'd0, 8'd0, 2'b11, 2'b11};
        tbl[5]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b11};
        tbl[6]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b11};
        tbl[7]  = '{1'b0, 3'd0, 8'd0, 2'b10, 2'b01};
        tbl[8]  = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b01};
        tbl[9]  = '{1'b0, 3'd0, 8'd0, 2'b01, 2'b00};
        tbl[10] = '{1'b0, 3'd0, 8'd0, 2'b10, 2'b10};
        tbl[11] = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b10};
        tbl[12] = '{1'b0, 3'd0, 8'd0, 2'b00, 2'b10};
        tbl[13] = '{1'b0, 3'd0, 8'd0, 2'b10, 2'b00};
        tbl[14] = '{1'b0, 3'd0, 8'd0, 2'b01, 2'b01};

        reset_n = 1'b0;
        ch_en   = '1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_slow", 32'(slow_clk), 32'd0);
        check("reset_dc", divided_clocks, 32'd0);
        reset_n = 1'b1;

        // Reset release and a mid-period divisor change on ch1.
        for (int i = 0; i < 15; i++) begin
            div_load  = tbl[i].load;
            div_sel   = tbl[i].sel;
            div_value = tbl[i].val;
            step();
            check("tbl_tick", 32'(tick[1:0]), 32'(tbl[i].exp_tick));
            check("tbl_slow", 32'(slow_clk[1:0]), 32'(tbl[i].exp_slow));
        end
        idle_inputs();

        // Divisors 0 and 1 on ch3/ch4, realigned by a restart.
        div_load = 1'b1; div_sel = 3'd3; div_value = 8'd0;
        step();
        div_sel = 3'd4; div_value = 8'd1;
        step();
        idle_inputs();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("div01_tick", 32'(tick[4:3]), 32'd3);
            check("div01_slow", 32'(slow_clk[4:3]), (k % 2 == 1) ? 32'd3 : 32'd0);
        end

        // ch2 frozen at count 3 for seven cycles, then resumes.
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ch_en[2] = (k >= 2 && k <= 8) ? 1'b0 : 1'b1;
            step();
            check("freeze_tick2", 32'(tick[2]), (k == 12) ? 32'd1 : 32'd0);
            check("freeze_slow2", 32'(slow_clk[2]), (k == 12) ? 32'd1 : 32'd0);
        end
        ch_en = '1;

        // Pending ch0=4 plus a ch1=6 load coinciding with the restart strobe.
        div_load = 1'b1; div_sel = 3'd0; div_value = 8'd4;
        step();
        div_sel = 3'd1; div_value = 8'd6; sync_restart = 1'b1;
        step();
        check("restart_slow", 32'(slow_clk), 32'd0);
        idle_inputs();
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                div_load = 1'b1; div_sel = 3'd7; div_value = 8'd2;
            end else begin
                idle_inputs();
            end
            step();
            check("rs_tick0", 32'(tick[0]), (k == 4 || k == 8) ? 32'd1 : 32'd0);
            check("rs_tick1", 32'(tick[1]), (k == 6) ? 32'd1 : 32'd0);
            check("rs_slow0", 32'(slow_clk[0]), (k >= 4 && k < 8) ? 32'd1 : 32'd0);
            check("rs_slow1", 32'(slow_clk[1]), (k >= 6) ? 32'd1 : 32'd0);
        end
        idle_inputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            div_load     = ($urandom_range(0, 7) == 0);
            div_sel      = 3'($urandom_range(0, 7));
            div_value    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 9));
            sync_restart = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) begin
                int b;
                b = int'($urandom_range(0, NUM_CH - 1));
                ch_en[b] = ~ch_en[b];
            end
            step();
        end
        idle_inputs();
        ch_en = '1;

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_tick", 32'(tick), 32'd0);
        check("async_slow", 32'(slow_clk), 32'd0);
        check("async_dc", divided_clocks, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("rerel_tick0", 32'(tick[0]), (k == 5) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
